// File: rtl/ram_sdp_be_clr_if.sv
// Write/read/clear bundle for the simple-dual-port byte-enable RAM.
// The master side issues requests; the slave side is the RAM.
interface ram_sdp_be_clr_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int BYTE_WIDTH = 8
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  clear;
    logic                  ready;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [NB-1:0]         wbe;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  re;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;

    modport master (
        output clear, we, waddr, wbe, wdata, re, raddr,
        input  ready, rdata, rvalid
    );

    modport slave (
        input  clear, we, waddr, wbe, wdata, re, raddr,
        output ready, rdata, rvalid
    );
endinterface

// File: rtl/ram_sdp_be_clr.sv
// Simple-dual-port RAM with byte enables, registered read, selectable
// read-during-write policy and a sweep engine that clears the array.
module ram_sdp_be_clr #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 7,
    parameter int                    BYTE_WIDTH     = 8,
    parameter int                    RDW_MODE       = 0,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input logic              clk,
    input logic              reset_n,
    ram_sdp_be_clr_if.slave  bus
);
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $fatal(1, "DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
    localparam logic   RST_READY = (CLEAR_ON_RESET == 0);
    localparam logic [ADDR_WIDTH:0] LAST_CNT = {1'b0, {ADDR_WIDTH{1'b1}}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [NB-1:0]         mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] rd_old;
    logic [DATA_WIDTH-1:0] rd_merged;
    logic                  rd_hit;

    // Word the read port would see if the concurrent write landed first.
    always_comb begin
        rd_old    = mem[bus.raddr];
        rd_merged = rd_old;
        for (int i = 0; i < NB; i++) begin
            if (bus.wbe[i]) begin
                rd_merged[i*BYTE_WIDTH +: BYTE_WIDTH] =
                    bus.wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        rd_hit = bus.we && (bus.waddr == bus.raddr);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        mem_we    = 1'b0;
        mem_addr  = bus.waddr;
        mem_be    = bus.wbe;
        mem_wdata = bus.wdata;
        unique case (state_q)
            ST_IDLE: begin
                mem_we = bus.we;
                if (bus.re) begin
                    rvalid_d = 1'b1;
                    if ((RDW_MODE != 0) && rd_hit) begin
                        rdata_d = rd_merged;
                    end else begin
                        rdata_d = rd_old;
                    end
                end
                if (bus.clear) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = cnt_q[ADDR_WIDTH-1:0];
                mem_be    = '1;
                mem_wdata = CLEAR_VALUE;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RST_STATE;
            cnt_q    <= '0;
            ready_q  <= RST_READY;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (mem_we && mem_be[i]) begin
                mem[mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                    mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    assign bus.ready  = ready_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
endmodule

// File: doc/ram_sdp_be_clr.md
Name: ram_sdp_be_clr

Overview:
- Parametrised simple-dual-port RAM: one write port and one read port, both on the same clock.
- Successor to the team's single-port, asynchronous-read 128x32 RAM.
- Adds per-byte write enables, a registered synchronous read with a valid strobe, and a selectable read-during-write policy.
- Adds a hardware clear engine that walks the whole array after reset or on request.
- Used as the scratch/buffer memory behind datapath blocks that need deterministic initial contents.

Parameters:
- DATA_WIDTH, 32, bits per word; must be an integer multiple of BYTE_WIDTH (elaboration-time check, fatal if not).
- ADDR_WIDTH, 7, address bits; depth = 2**ADDR_WIDTH.
- BYTE_WIDTH, 8, bits per byte lane; NB = DATA_WIDTH/BYTE_WIDTH.
- RDW_MODE, 0, same-address read-during-write policy: 0 = old data (read-first), 1 = new merged data (write-first).
- CLEAR_ON_RESET, 1, 1 = clear engine runs after reset release; 0 = ready immediately after reset.
- CLEAR_VALUE, 0, DATA_WIDTH-bit word written to every location by the clear engine.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear request; single-cycle pulse or level.
- ready  out  1  registered; 1 = write/read requests are accepted.
- we  in  1  write request.
- waddr  in  ADDR_WIDTH  write address.
- wbe  in  NB  byte-lane write enables; bit i covers wdata[i*BYTE_WIDTH +: BYTE_WIDTH].
- wdata  in  DATA_WIDTH  write data.
- re  in  1  read request.
- raddr  in  ADDR_WIDTH  read address.
- rdata  out  DATA_WIDTH  registered read data.
- rvalid  out  1  registered; high one cycle after an accepted read.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - rdata=0, rvalid=0, clear counter=0.
  - State = CLEAR and ready=0 if CLEAR_ON_RESET=1; otherwise state = IDLE and ready=1.
  - Array contents are not reset by reset_n itself.
- State machine has two states:
  - IDLE: ready=1.
    - we=1: write accepted; every lane with wbe[i]=1 is updated at the edge; lanes with wbe[i]=0 keep their old value.
    - we=1 with wbe=0: no change.
    - re=1: read accepted; rdata = word at raddr and rvalid=1 after the edge.
    - re=0: rvalid=0 next cycle; rdata holds its previous value.
    - Writes and reads are independent and may occur in the same cycle.
    - clear=1 sampled: moves to CLEAR with counter=0 and ready=0 after the edge.
    - A write or read presented in the same cycle as clear is still accepted; the subsequent clear overwrites any write.
  - CLEAR: each edge writes CLEAR_VALUE (all lanes) to address = counter, then counter increments.
    - The edge that writes address 2**ADDR_WIDTH-1 moves to IDLE with ready=1.
    - ready is therefore low for exactly 2**ADDR_WIDTH cycles.
    - we, re and clear are ignored while in CLEAR; rvalid=0 and rdata holds.
- Read-during-write, same address in the same IDLE cycle:
  - RDW_MODE=0: rdata = pre-write word.
  - RDW_MODE=1: rdata = merged word (enabled lanes from wdata, other lanes old).
  - Different addresses: no interaction.
- Read latency is exactly 1 cycle. Throughput is 1 write plus 1 read per cycle.
- The counter is ADDR_WIDTH+1 bits or uses an equivalent terminal detect; no wrap-around past the last address.
- Reset asserted mid-clear aborts the sweep. If CLEAR_ON_RESET=1, the sweep restarts from address 0 after release.
- The array infers block RAM. The reset drives only the control registers and rdata/rvalid, never the array.

Test Plan:
- Reset, CLEAR_ON_RESET=1, ADDR_WIDTH=7 -> ready=0 for 128 cycles after release, then 1; reads of addresses 0, 64 and 127 return 0x00000000 with rvalid one cycle after re.
- Write addr 5, wdata=0xAABBCCDD, wbe=4'b1111; then write addr 5, wdata=0x11223344, wbe=4'b0101 -> read addr 5 returns 0xAA22CC44; write with wbe=0 leaves the word unchanged.
- Write addr 9 = 0x12345678; next cycle write addr 9 = 0xCAFEF00D (wbe all ones) while re at addr 9 -> RDW_MODE=0 gives rdata 0x12345678; RDW_MODE=1 gives 0xCAFEF00D; with wbe=4'b0011, RDW_MODE=1 gives 0x1234F00D.
- Back-to-back reads of addresses 1, 2, 3 with re held high -> rvalid high for 3 consecutive cycles, each data lagging its address by one cycle; re dropped -> rvalid=0 and rdata holds the last value.
- Fill addresses with non-zero data, pulse clear -> ready low for 128 cycles; we/re issued during the sweep are ignored (rvalid stays 0); afterwards all locations read CLEAR_VALUE.
- Assert reset_n low at sweep address 60, release -> sweep restarts at address 0 and ready rises 128 cycles after release. Repeat with CLEAR_ON_RESET=0 -> ready=1 in the first cycle after release.
